// File: rtl/idecode32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : idecode32_pkg
//  Description : Shared constants and helpers for the decode/register-file
//                stage: data width, opcode values and fixed register indices.
//  Revision    : 1.0  initial release
// ============================================================================
package idecode32_pkg;

   localparam int unsigned DATA_W = 32;

   // Opcodes (Instruction[31:26]) that matter to this stage
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;

   // Architecturally special registers
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_SP   = 5'd29;
   localparam logic [4:0] REG_RA   = 5'd31;

   // Logical immediates are zero-extended; everything else is sign-extended
   function automatic logic is_zero_ext(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

endpackage : idecode32_pkg
`default_nettype wire

// File: rtl/idecode32_regfile32.sv
`default_nettype none
// ============================================================================
//  Module      : regfile32
//  Description : 32 x 32-bit general register file. Asynchronous active-high
//                reset, one synchronous write port, three combinational read
//                ports (rs, rt, debug). Index 0 always reads as zero.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile32
   import idecode32_pkg::*;
#(
   parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_7FFC,
   parameter bit                DBG_EN   = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [4:0]        rd_addr_1,
   output logic [DATA_W-1:0] rd_data_1,
   input  logic [4:0]        rd_addr_2,
   output logic [DATA_W-1:0] rd_data_2,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] r_regs [32];

   // Register array: async clear (sp gets its boot value), write on rising edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= (5'(i) == REG_SP) ? SP_RESET : '0;
         end
      end else if (wr_en && (wr_addr != REG_ZERO)) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   // Operand reads: no bypass, so a same-cycle write is seen only after the edge
   always_comb begin
      rd_data_1 = (rd_addr_1 == REG_ZERO) ? '0 : r_regs[rd_addr_1];
      rd_data_2 = (rd_addr_2 == REG_ZERO) ? '0 : r_regs[rd_addr_2];
   end

   generate
      if (DBG_EN) begin : g_dbg_on
         // Debug read port, side-effect free
         always_comb begin
            dbg_data = (dbg_addr == REG_ZERO) ? '0 : r_regs[dbg_addr];
         end
      end else begin : g_dbg_off
         assign dbg_data = '0;
      end
   endgenerate

endmodule : regfile32
`default_nettype wire

// File: rtl/idecode32.sv
`default_nettype none
// ============================================================================
//  Module      : idecode32
//  Description : Decode / register-file stage of the single-cycle MIPS CPU.
//                Selects write-back address and data (ALU, memory, jal link),
//                extends the 16-bit immediate and exposes rs/rt operands.
//  Revision    : 1.0  initial release
// ============================================================================
module idecode32
   import idecode32_pkg::*;
#(
   parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_7FFC,
   parameter bit                DBG_EN   = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] Instruction,
   input  logic [DATA_W-1:0] opcplus4,
   input  logic [DATA_W-1:0] ALU_result,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              Jal,
   input  logic              RegWrite,
   input  logic              MemtoReg,
   input  logic              RegDst,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] Read_data_1,
   output logic [DATA_W-1:0] Read_data_2,
   output logic [DATA_W-1:0] Sign_extend,
   output logic [DATA_W-1:0] dbg_data
);

   logic [5:0]        w_opcode;
   logic [4:0]        w_rs;
   logic [4:0]        w_rt;
   logic [4:0]        w_rd;
   logic [15:0]       w_imm;
   logic [4:0]        w_wr_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic              w_wr_en;

   assign w_opcode = Instruction[31:26];
   assign w_rs     = Instruction[25:21];
   assign w_rt     = Instruction[20:16];
   assign w_rd     = Instruction[15:11];
   assign w_imm    = Instruction[15:0];

   // Write-back selection: jal wins over RegDst/MemtoReg and forces a write of $31.
   // The link value is stored as-is (word address) because fetch uses it directly on jr.
   always_comb begin
      w_wr_addr = w_rt;
      w_wr_data = ALU_result;
      if (Jal) begin
         w_wr_addr = REG_RA;
         w_wr_data = opcplus4;
      end else begin
         if (RegDst)   w_wr_addr = w_rd;
         if (MemtoReg) w_wr_data = mem_data;
      end
      w_wr_en = (RegWrite | Jal) & (w_wr_addr != REG_ZERO);
   end

   // Immediate extension: andi/ori/xori zero-extend, all others sign-extend
   always_comb begin
      if (is_zero_ext(w_opcode)) Sign_extend = {16'h0000, w_imm};
      else                       Sign_extend = {{16{w_imm[15]}}, w_imm};
   end

   regfile32 #(
      .SP_RESET (SP_RESET),
      .DBG_EN   (DBG_EN)
   ) u_regfile (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (w_wr_en),
      .wr_addr   (w_wr_addr),
      .wr_data   (w_wr_data),
      .rd_addr_1 (w_rs),
      .rd_data_1 (Read_data_1),
      .rd_addr_2 (w_rt),
      .rd_data_2 (Read_data_2),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

endmodule : idecode32
`default_nettype wire
